sync_fifo_param: RTL and testbench

Single-clock, parametrised FIFO: the next generation of the team's FIFO block, generalised in data width and depth, with a fill-level output, programmable almost-full/almost-empty thresholds and a selectable first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer in the same clock domain. It exposes the same wr_en/wdata/rd_en/rdata/full/empty/overflow/underflow signal set used by the existing FIFO benches, so those drivers and monitors attach unchanged.

---
 rtl/fifo_pkg.sv | 11 +
 rtl/fifo_ram.sv | 20 ++
 rtl/sync_fifo_param.sv | 72 +++++++
 tb/tb_sync_fifo_param.sv | 102 ++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, pointer type, depth check and read-mode constants for the FIFO family
package fifo_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 16;
  localparam int FWFT_OFF  = 0;
  localparam int FWFT_ON   = 1;
  typedef logic [$clog2(DEPTH_DEF)-1:0] ptr_t;
  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x WIDTH storage, synchronous write, asynchronous read, no reset
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  // store the accepted write word
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with fill level, almost flags, error pulses and optional FWFT read
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = FWFT_OFF
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_empty,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW + 1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW + 1)'(AE_LEVEL);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 2");
  end

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] ram_rdata, rdata_q;
  logic             wr_acc, rd_acc;

  assign empty        = count == '0;
  assign full         = count == DEPTH_C;
  assign almost_empty = count <= AE_C;
  assign almost_full  = count >= AF_C;
  assign rd_acc       = rd_en && !empty;
  assign wr_acc       = wr_en && (!full || rd_acc);
  assign rdata        = (FWFT == FWFT_ON) ? ram_rdata : rdata_q;

  fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // pointers, occupancy, registered read word and one-cycle error pulses
  always_ff @(posedge clk or negedge res)
    if (!res) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rdata_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_acc ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr    <= rd_acc ? rd_ptr + 1'b1 : rd_ptr;
      count     <= (wr_acc && !rd_acc) ? count + 1'b1 : (rd_acc && !wr_acc) ? count - 1'b1 : count;
      rdata_q   <= rd_acc ? ram_rdata : rdata_q;
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && !rd_acc;
    end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: standard and FWFT FIFOs driven in lockstep against a queue model
module tb_sync_fifo_param;
  localparam int D = 16;
  logic       clk = 1'b0, res = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata_s, rdata_f;
  logic       empty_s, full_s, ae_s, af_s, ovf_s, unf_s;
  logic       empty_f, full_f, ae_f, af_f, ovf_f, unf_f;
  logic [4:0] count_s, count_f;
  int         checks = 0, errors = 0;
  logic [7:0] q[$];
  logic [7:0] exp_rd = '0;
  logic [7:0] saved[$];

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(8), .DEPTH(D), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_std (
    .clk(clk), .res(res), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en), .rdata(rdata_s),
    .empty(empty_s), .full(full_s), .almost_empty(ae_s), .almost_full(af_s),
    .count(count_s), .overflow(ovf_s), .underflow(unf_s));

  sync_fifo_param #(.WIDTH(8), .DEPTH(D), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
    .clk(clk), .res(res), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en), .rdata(rdata_f),
    .empty(empty_f), .full(full_f), .almost_empty(ae_f), .almost_full(af_f),
    .count(count_f), .overflow(ovf_f), .underflow(unf_f));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input logic ovf, input logic unf);
    int n = q.size();
    chk("count_s", 32'(count_s), 32'(n));
    chk("count_f", 32'(count_f), 32'(n));
    chk("empty", {30'd0, empty_s, empty_f}, {30'd0, n == 0, n == 0});
    chk("full", {30'd0, full_s, full_f}, {30'd0, n == D, n == D});
    chk("almost_empty", {30'd0, ae_s, ae_f}, {30'd0, n <= 2, n <= 2});
    chk("almost_full", {30'd0, af_s, af_f}, {30'd0, n >= 14, n >= 14});
    chk("overflow", {30'd0, ovf_s, ovf_f}, {30'd0, ovf, ovf});
    chk("underflow", {30'd0, unf_s, unf_f}, {30'd0, unf, unf});
    chk("rdata_std", 32'(rdata_s), 32'(exp_rd));
    if (n > 0) chk("rdata_fwft", 32'(rdata_f), 32'(q[0]));
  endtask

  task automatic step(input logic we, input logic [7:0] wd, input logic re);
    logic racc, wacc;
    wr_en = we; wdata = wd; rd_en = re;
    @(posedge clk);
    racc = re && q.size() > 0;
    wacc = we && (q.size() < D || racc);
    if (racc) exp_rd = q.pop_front();
    if (wacc) q.push_back(wd);
    #1 chk_all(we && !wacc, re && !racc);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 chk_all(1'b0, 1'b0);
    @(negedge clk) res = 1'b1;
    #1 chk_all(1'b0, 1'b0);
    for (int i = 0; i < D; i++) step(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < D; i++) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < D; i++) step(1'b1, 8'($urandom), 1'b0);
    saved = q;
    step(1'b1, 8'hEE, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < D; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("drain_orig", 32'(rdata_s), 32'(saved[i]));
    end
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < D; i++) step(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b1);
    for (int i = 0; i < D; i++) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b1);
    for (int i = 0; i < 300; i++)
      step(($urandom % 3) != 0, 8'($urandom), ($urandom % 3) != 0);
    for (int i = 0; i < D + 2; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hA5, 1'b0);
    chk("fwft_a5", 32'(rdata_f), 32'h0000_00A5);
    step(1'b0, 8'h00, 1'b0);
    chk("fwft_a5_hold", 32'(rdata_f), 32'h0000_00A5);
    for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'b0);
    chk("count_at_7", 32'(count_s), 32'd7);
    #2 res = 1'b0;
    q.delete();
    exp_rd = '0;
    #1 chk_all(1'b0, 1'b0);
    @(negedge clk) res = 1'b1;
    for (int i = 0; i < 40; i++)
      step(($urandom % 2) != 0, 8'($urandom), ($urandom % 2) != 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
